// File: rtl/trigger_framer_if.sv
// rtl/trigger_framer_if.sv - AXI-Stream-like frame output bundle for trigger_framer
interface trigger_framer_if;
    logic [15:0] tdata;
    logic        tuser;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/trigger_framer.sv
// rtl/trigger_framer.sv - edge/level trigger, fixed-length framer and output FIFO (optional TRIG_HYST_EN)
module trigger_framer #(
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter int AUTO_TO    = 65535
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce_i,
    input  logic signed [15:0] s_data_i,
    input  logic               s_valid_i,
    input  logic signed [15:0] trig_level_i,
    input  logic               trig_edge_i,
    input  logic [1:0]         trig_mode_i,
    input  logic               arm_i,
    input  logic [15:0]        holdoff_i,
`ifdef TRIG_HYST_EN
    input  logic [15:0]        trig_hyst_i,
`endif
    trigger_framer_if.master   m_axis,
    output logic               busy_o,
    output logic               triggered_o,
    output logic               overflow_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
    localparam logic [15:0] AUTO_LIM = 16'(AUTO_TO);

    logic [1:0]         state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        hold_q, hold_d;
    logic [15:0]        auto_q, auto_d;
    logic signed [15:0] prev_q, prev_d;
    logic               prev_valid_q, prev_valid_d;
    logic               triggered_q, overflow_q;

    logic single_mode, auto_mode, sample, edge_hit, auto_fire, trig_fire;
    logic go_armed, go_exit;
    logic push, push_user, push_last;

    assign single_mode = (trig_mode_i == 2'd2);
    assign auto_mode   = (trig_mode_i == 2'd0);
    assign sample      = ce_i && s_valid_i;
    assign auto_fire   = auto_mode && (auto_q == AUTO_LIM);

`ifdef TRIG_HYST_EN
    logic               rearm_q, rearm_d, rearm_hit;
    logic signed [17:0] lvl_x, cur_x, hyst_x;

    // 18-bit thresholds so level -/+ hysteresis never wraps
    assign lvl_x     = {{2{trig_level_i[15]}}, trig_level_i};
    assign cur_x     = {{2{s_data_i[15]}}, s_data_i};
    assign hyst_x    = {2'b00, trig_hyst_i};
    assign rearm_hit = trig_edge_i ? (cur_x > lvl_x + hyst_x) : (cur_x < lvl_x - hyst_x);
`endif

    // Edge compare against the previous in-ARMED sample; first sample after arming never fires
    always_comb begin
        edge_hit = 1'b0;
        if (!trig_edge_i) begin
            edge_hit = prev_valid_q && (prev_q < trig_level_i) && (s_data_i >= trig_level_i);
        end else begin
            edge_hit = prev_valid_q && (prev_q > trig_level_i) && (s_data_i <= trig_level_i);
        end
`ifdef TRIG_HYST_EN
        edge_hit = edge_hit && rearm_q;
`endif
    end

    assign trig_fire = (state_q == ST_ARMED) && sample && (edge_hit || auto_fire);

    // Capture FSM next state, counters and the FIFO push request
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        auto_d       = auto_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
`ifdef TRIG_HYST_EN
        rearm_d      = rearm_q;
`endif
        push         = 1'b0;
        push_user    = 1'b0;
        push_last    = 1'b0;
        go_armed     = 1'b0;
        go_exit      = 1'b0;
        if (ce_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (!single_mode || arm_i) go_armed = 1'b1;
                end
                ST_ARMED: begin
                    if (s_valid_i) begin
                        if (trig_fire) begin
                            push      = 1'b1;
                            push_user = 1'b1;
                            cnt_d     = 16'd1;
                            state_d   = ST_CAPTURE;
`ifdef TRIG_HYST_EN
                            rearm_d   = 1'b0;
`endif
                        end else begin
                            prev_d       = s_data_i;
                            prev_valid_d = 1'b1;
                            if (auto_q != AUTO_LIM) auto_d = auto_q + 16'd1;
`ifdef TRIG_HYST_EN
                            if (rearm_hit) rearm_d = 1'b1;
`endif
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (s_valid_i) begin
                        push      = 1'b1;
                        push_last = (cnt_q == LAST_IDX);
                        cnt_d     = cnt_q + 16'd1;
                        if (push_last) begin
                            if (holdoff_i == 16'd0) begin
                                go_exit = 1'b1;
                            end else begin
                                state_d = ST_HOLDOFF;
                                hold_d  = 16'd0;
                            end
                        end
                    end
                end
                default: begin
                    // Compare with >= so shrinking holdoff mid-count cannot strand the FSM
                    if (s_valid_i) begin
                        if ({1'b0, hold_q} + 17'd1 >= {1'b0, holdoff_i}) go_exit = 1'b1;
                        else hold_d = hold_q + 16'd1;
                    end
                end
            endcase
            if (go_exit) begin
                if (single_mode) state_d = ST_IDLE;
                else go_armed = 1'b1;
            end
            if (go_armed) begin
                state_d      = ST_ARMED;
                prev_valid_d = 1'b0;
                auto_d       = 16'd0;
`ifdef TRIG_HYST_EN
                rearm_d      = 1'b0;
`endif
            end
        end
    end

    // Input-side state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            hold_q       <= 16'd0;
            auto_q       <= 16'd0;
            prev_q       <= 16'sd0;
            prev_valid_q <= 1'b0;
            triggered_q  <= 1'b0;
`ifdef TRIG_HYST_EN
            rearm_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            auto_q       <= auto_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            triggered_q  <= trig_fire;
`ifdef TRIG_HYST_EN
            rearm_q      <= rearm_d;
`endif
        end
    end

    logic [AW:0]   wr_ptr_q, rd_ptr_q, fill;
    logic [AW-1:0] newest_idx;
    logic [17:0]   mem_q [FIFO_DEPTH];
    logic [17:0]   head;
    logic          fifo_empty, fifo_full, pop, wr_en, drop;

    assign fill       = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == (AW + 1)'(FIFO_DEPTH));
    assign pop        = !fifo_empty && m_axis.tready;
    assign wr_en      = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;
    assign newest_idx = wr_ptr_q[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    // FIFO pointers; reset flushes any partial frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; a dropped final sample still terminates the frame on the newest entry
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {push_user, push_last, s_data_i};
        end else if (drop && push_last) begin
            mem_q[newest_idx][16] <= 1'b1;
        end
    end

    // Sticky overflow; arm clears it unless a drop happens in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   overflow_q <= 1'b0;
        else if (drop)  overflow_q <= 1'b1;
        else if (arm_i) overflow_q <= 1'b0;
    end

    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = fifo_empty ? 16'd0 : head[15:0];
    assign m_axis.tlast  = !fifo_empty && head[16];
    assign m_axis.tuser  = !fifo_empty && head[17];
    assign busy_o        = (state_q == ST_CAPTURE) || (state_q == ST_HOLDOFF);
    assign triggered_o   = triggered_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_trigger_framer.sv
// tb/tb_trigger_framer.sv - directed self-checking bench for trigger_framer
module tb_trigger_framer;
    localparam int FRAME_LEN  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int AUTO_TO    = 16;

    localparam int ST_IDLE  = 0;
    localparam int ST_ARMED = 1;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               ce;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic signed [15:0] trig_level;
    logic               trig_edge;
    logic [1:0]         trig_mode;
    logic               arm;
    logic [15:0]        holdoff;
    logic               busy, triggered, overflow;
`ifdef TRIG_HYST_EN
    logic [15:0]        trig_hyst;
`endif

    trigger_framer_if mif ();

    always #5 clk = ~clk;

    trigger_framer #(.FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH), .AUTO_TO(AUTO_TO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ce_i         (ce),
        .s_data_i     (s_data),
        .s_valid_i    (s_valid),
        .trig_level_i (trig_level),
        .trig_edge_i  (trig_edge),
        .trig_mode_i  (trig_mode),
        .arm_i        (arm),
        .holdoff_i    (holdoff),
`ifdef TRIG_HYST_EN
        .trig_hyst_i  (trig_hyst),
`endif
        .m_axis       (mif),
        .busy_o       (busy),
        .triggered_o  (triggered),
        .overflow_o   (overflow)
    );

    typedef struct {
        logic [15:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Record every accepted output beat
    always @(negedge clk) begin
        if (reset_n && mif.tvalid && mif.tready) q.push_back('{mif.tdata, mif.tuser, mif.tlast});
    end

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        s_data  = 16'(v);
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
        q.delete();
    endtask

    function automatic int k_val(input int k);
        return (k % 2 == 1) ? k : -k - 1;
    endfunction

    function automatic int k_of(input int v);
        return (v >= 0) ? v : -v - 1;
    endfunction

    initial begin
        int ulist[$];
        int llist[$];
        int nlast;

        reset_n = 1'b0; ce = 1'b1; s_valid = 1'b0; s_data = '0;
        trig_level = '0; trig_edge = 1'b0; trig_mode = 2'd1; arm = 1'b0;
        holdoff = '0; mif.tready = 1'b1;
`ifdef TRIG_HYST_EN
        trig_hyst = 16'd0;
`endif
        idle(2);
        check_eq("rst_tvalid", mif.tvalid, 0);
        check_eq("rst_tdata", mif.tdata, 0);
        check_eq("rst_tuser", mif.tuser, 0);
        check_eq("rst_tlast", mif.tlast, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_triggered", triggered, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_state", dut.state_q, ST_IDLE);

        // normal mode ramp
        reset_n = 1'b1;
        idle(2);
        q.delete();
        for (int v = -5; v <= 20; v++) begin
            send(v);
            if (v == 0) begin
                check_eq("t1_triggered", triggered, 1);
                check_eq("t1_busy", busy, 1);
                check_eq("t1_lat_tvalid", mif.tvalid, 1);
                check_eq("t1_lat_tdata", $signed(mif.tdata), 0);
                check_eq("t1_lat_tuser", mif.tuser, 1);
            end
            if (v == 1) check_eq("t1_trig_pulse", triggered, 0);
        end
        idle(3);
        check_eq("t1_beats", q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t1_data%0d", i), $signed(q[i].d), i);
            check_eq($sformatf("t1_user%0d", i), q[i].u, (i == 0) ? 1 : 0);
            check_eq($sformatf("t1_last%0d", i), q[i].l, (i == 7) ? 1 : 0);
        end

        // single mode
        trig_mode = 2'd2;
        do_reset();
        for (int v = -5; v <= 5; v++) send(v);
        idle(2);
        check_eq("t2_noarm_beats", q.size(), 0);
        check_eq("t2_noarm_state", dut.state_q, ST_IDLE);
        arm = 1'b1;
        idle(1);
        arm = 1'b0;
        check_eq("t2_armed", dut.state_q, ST_ARMED);
        ce = 1'b0;
        send(-1);
        send(0);
        check_eq("t2_ce_trig", triggered, 0);
        check_eq("t2_ce_beats", q.size(), 0);
        ce = 1'b1;
        for (int v = -5; v <= 10; v++) send(v);
        idle(3);
        check_eq("t2_beats", q.size(), 8);
        check_eq("t2_first", $signed(q[0].d), 0);
        check_eq("t2_first_user", q[0].u, 1);
        check_eq("t2_last", $signed(q[7].d), 7);
        check_eq("t2_last_flag", q[7].l, 1);
        check_eq("t2_back_idle", dut.state_q, ST_IDLE);
        for (int v = -5; v <= 10; v++) send(v);
        idle(2);
        check_eq("t2_one_frame", q.size(), 8);

        // auto mode
        trig_mode = 2'd0;
        do_reset();
        for (int n = 1; n <= 24; n++) begin
            send(-100);
            if (n == 16) check_eq("t3_no_trig16", triggered, 0);
            if (n == 17) check_eq("t3_trig17", triggered, 1);
        end
        idle(3);
        check_eq("t3_beats", q.size(), 8);
        check_eq("t3_data", $signed(q[0].d), -100);
        check_eq("t3_user", q[0].u, 1);
        check_eq("t3_last", q[7].l, 1);

        // overflow on stalled sink
        trig_mode = 2'd1;
        do_reset();
        send(-2);
        send(-1);
        send(0);
        mif.tready = 1'b0;
        for (int v = 1; v <= 7; v++) send(v);
        idle(3);
        check_eq("t4_overflow", overflow, 1);
        check_eq("t4_hold_data", $signed(mif.tdata), 0);
        check_eq("t4_hold_user", mif.tuser, 1);
        mif.tready = 1'b1;
        idle(6);
        check_eq("t4_beats", q.size(), 4);
        nlast = 0;
        for (int i = 0; i < q.size(); i++) begin
            check_eq($sformatf("t4_data%0d", i), $signed(q[i].d), i);
            if (q[i].l) nlast++;
        end
        check_eq("t4_last_on_3", q[3].l, 1);
        check_eq("t4_one_tlast", nlast, 1);
        arm = 1'b1;
        idle(1);
        arm = 1'b0;
        check_eq("t4_ovf_clear", overflow, 0);
        check_eq("t4_arm_state", dut.state_q, ST_ARMED);

        // holdoff with continuous crossings
        holdoff = 16'd5;
        do_reset();
        for (int k = 0; k <= 24; k++) begin
            send(k_val(k));
            if (k == 10) check_eq("t5_busy_hold", busy, 1);
        end
        idle(4);
        check_eq("t5_beats", q.size(), 16);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].u) ulist.push_back(k_of(int'($signed(q[i].d))));
            if (q[i].l) llist.push_back(k_of(int'($signed(q[i].d))));
        end
        check_eq("t5_nuser", ulist.size(), 2);
        check_eq("t5_nlast", llist.size(), 2);
        check_eq("t5_user0", ulist[0], 1);
        check_eq("t5_last0", llist[0], 8);
        check_eq("t5_user1", ulist[1], 15);
        check_eq("t5_last1", llist[1], 22);

        // async reset mid-capture
        mif.tready = 1'b0;
        for (int k = 25; k <= 30; k++) send(k_val(k));
        check_eq("t5_cap_busy", busy, 1);
        check_eq("t5_cap_tvalid", mif.tvalid, 1);
        reset_n = 1'b0;
        #1;
        check_eq("t5_rst_tvalid", mif.tvalid, 0);
        check_eq("t5_rst_state", dut.state_q, ST_IDLE);
        check_eq("t5_rst_busy", busy, 0);
        mif.tready = 1'b1;

        // hysteresis / plain edge on small noise
        holdoff = 16'd0;
`ifdef TRIG_HYST_EN
        trig_hyst = 16'd10;
`endif
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(-3);
            send(3);
        end
        idle(3);
`ifdef TRIG_HYST_EN
        check_eq("t6_noise_beats", q.size(), 0);
`else
        check_eq("t6_noise_beats", q.size(), 8);
`endif
        q.delete();
        send(-11);
        send(1);
        check_eq("t6_trig", triggered, 1);
        idle(2);
        check_eq("t6_data", $signed(q[0].d), 1);
        check_eq("t6_user", q[0].u, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
